stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr.sv | 115 +++++++++++
 tb/tb_stream_mux_rr.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-input stream multiplexer with round-robin or fixed-priority arbitration and a registered output.
// Optional packet lock (grant held until in_last) is enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int MODE = 0,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N*W-1:0]   in_data,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [N-1:0]     in_last,
   output logic             out_last,
`endif
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_sel,
   output logic             out_valid,
   input  logic             out_ready
);

   logic             load;
   logic             gnt_any;
   logic [SEL_W-1:0] gnt_idx;
   logic [W-1:0]     gnt_data;
   logic             gnt_last;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_inc;
   logic [SEL_W-1:0] start;
   logic             lock;
   logic [SEL_W-1:0] lock_idx;

   assign load    = ~out_valid | out_ready;
   assign start   = (MODE == 0) ? ptr : '0;
   assign ptr_inc = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

   // Two passes give the wrap-around search: indices >= start first, then from 0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      gnt_data = '0;
      if (lock) begin
         gnt_idx = lock_idx;
         for (int i = 0; i < N; i++)
            if (lock_idx == SEL_W'(i)) gnt_any = in_valid[i];
      end else begin
         for (int i = 0; i < N; i++)
            if (!gnt_any && in_valid[i] && SEL_W'(i) >= start) begin
               gnt_any = 1'b1;
               gnt_idx = SEL_W'(i);
            end
         for (int i = 0; i < N; i++)
            if (!gnt_any && in_valid[i]) begin
               gnt_any = 1'b1;
               gnt_idx = SEL_W'(i);
            end
      end
      for (int i = 0; i < N; i++)
         if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*W +: W];
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++)
         in_ready[i] = load & gnt_any & (gnt_idx == SEL_W'(i)) & ~reset;
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (gnt_any) begin
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
            out_valid <= 1'b1;
            // Round-robin pointer moves past the winner, but only at a packet boundary.
            if (MODE == 0 && gnt_last) ptr <= ptr_inc;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   always_comb begin
      gnt_last = 1'b0;
      for (int i = 0; i < N; i++)
         if (gnt_idx == SEL_W'(i)) gnt_last = in_last[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock     <= 1'b0;
         lock_idx <= '0;
         out_last <= 1'b0;
      end else if (load && gnt_any) begin
         out_last <= gnt_last;
         lock     <= ~gnt_last;
         lock_idx <= gnt_idx;
      end
   end
`else
   assign gnt_last = 1'b1;
   assign lock     = 1'b0;
   assign lock_idx = '0;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin and a fixed-priority instance share one stimulus.
// The packet-lock steps compile only when STREAM_MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_last;
   logic        out_ready;
   logic [3:0]  ready0, ready1;
   logic [7:0]  data0, data1;
   logic [1:0]  sel0, sel1;
   logic        valid0, valid1;
   logic        last0, last1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.N(4), .W(8), .MODE(0)) dut_rr (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ready0),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .in_last(in_last), .out_last(last0),
`endif
      .out_data(data0), .out_sel(sel0), .out_valid(valid0), .out_ready(out_ready)
   );

   stream_mux_rr #(.N(4), .W(8), .MODE(1)) dut_fp (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ready1),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .in_last(in_last), .out_last(last1),
`endif
      .out_data(data1), .out_sel(sel1), .out_valid(valid1), .out_ready(out_ready)
   );

`ifndef STREAM_MUX_PKT_LOCK_EN
   assign last0 = 1'b0;
   assign last1 = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      in_last   = 4'b1111;
      in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

      // Reset held two cycles with every channel valid.
      tick();
      tick();
      check("rst_valid", 32'(valid0), 32'd0);
      check("rst_data", 32'(data0), 32'd0);
      check("rst_sel", 32'(sel0), 32'd0);
      check("rst_ready", 32'(ready0), 32'd0);
      check("rst_ready_fp", 32'(ready1), 32'd0);
      check("rst_valid_fp", 32'(valid1), 32'd0);
      reset = 1'b0;
      #1;
      check("first_grant", 32'(ready0), 32'b0001);

      // Round-robin sweep: 0,1,2,3,0 one per cycle; fixed priority keeps channel 0.
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_valid", 32'(valid0), 32'd1);
         check("rr_sel", 32'(sel0), 32'(k % 4));
         check("rr_data", 32'(data0), 32'(8'hA0 + k % 4));
         check("fp_sel_all", 32'(sel1), 32'd0);
      end

      // Load A1, then stall for three cycles.
      tick();
      check("bp_pre_data", 32'(data0), 32'hA1);
      out_ready = 1'b0;
      #1;
      check("bp_ready", 32'(ready0), 32'b0000);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_data", 32'(data0), 32'hA1);
         check("bp_sel", 32'(sel0), 32'd1);
         check("bp_valid", 32'(valid0), 32'd1);
         check("bp_ready_hold", 32'(ready0), 32'b0000);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(ready0), 32'b0100);
      tick();
      check("bp_drain_sel", 32'(sel0), 32'd2);
      check("bp_drain_data", 32'(data0), 32'hA2);

      // Pointer now 3; only channels 0 and 2 valid.
      in_valid = 4'b0101;
      #1;
      check("wrap_ready", 32'(ready0), 32'b0001);
      tick();
      check("wrap_sel0", 32'(sel0), 32'd0);
      check("wrap_data0", 32'(data0), 32'hA0);
      tick();
      check("skip_sel2", 32'(sel0), 32'd2);
      tick();
      check("skip_sel0", 32'(sel0), 32'd0);
      in_valid = 4'b0000;
      tick();
      check("idle_valid", 32'(valid0), 32'd0);
      check("idle_data_hold", 32'(data0), 32'hA0);
      check("idle_sel_hold", 32'(sel0), 32'd0);

      // Fixed priority with 1110: channel 1 every cycle; round-robin from ptr=1 goes 1,2.
      in_valid = 4'b1110;
      #1;
      check("fp_ready", 32'(ready1), 32'b0010);
      check("rr_ready_1110", 32'(ready0), 32'b0010);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("fp_sel", 32'(sel1), 32'd1);
         check("fp_data", 32'(data1), 32'hA1);
         check("rr_1110_sel", 32'(sel0), 32'(1 + k));
      end
      check("rr_ptr3_ready", 32'(ready0), 32'b1000);

      // Mid-run reset drops the held word and returns the pointer to 0.
      reset = 1'b1;
      #1;
      check("mid_rst_ready", 32'(ready0), 32'b0000);
      tick();
      check("mid_rst_valid", 32'(valid0), 32'd0);
      check("mid_rst_valid_fp", 32'(valid1), 32'd0);
      check("mid_rst_data", 32'(data0), 32'd0);
      reset = 1'b0;
      in_valid = 4'b1111;
      #1;
      check("mid_rst_ptr0", 32'(ready0), 32'b0001);

`ifdef STREAM_MUX_PKT_LOCK_EN
      // Move pointer to 2, then channel 2 sends a 3-word packet with a gap.
      in_valid = 4'b0011;
      tick();
      tick();
      check("lk_pre_sel", 32'(sel0), 32'd1);
      in_valid = 4'b0111;
      in_last  = 4'b1011;
      #1;
      check("lk_ready2", 32'(ready0), 32'b0100);
      tick();
      check("lk_w0_sel", 32'(sel0), 32'd2);
      check("lk_w0_last", 32'(last0), 32'd0);
      in_valid = 4'b0011;
      #1;
      check("lk_gap_ready", 32'(ready0), 32'b0000);
      tick();
      check("lk_gap_valid", 32'(valid0), 32'd0);
      in_valid = 4'b0111;
      tick();
      check("lk_w1_sel", 32'(sel0), 32'd2);
      check("lk_w1_last", 32'(last0), 32'd0);
      in_last = 4'b1111;
      tick();
      check("lk_w2_sel", 32'(sel0), 32'd2);
      check("lk_w2_last", 32'(last0), 32'd1);
      in_valid = 4'b1111;
      tick();
      check("lk_after_sel", 32'(sel0), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
